// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: arbiter state encoding and default frame/burst constants
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WREQ,
        WBUSY,
        RREQ,
        RBUSY
    } arb_state_t;

    localparam int          DEF_ADDR_W        = 24;
    localparam logic [23:0] DEF_MIN_ADDR      = 24'd0;
    localparam logic [23:0] DEF_MAX_ADDR      = 24'd307200;
    localparam logic [9:0]  DEF_WR_BURST      = 10'd256;
    localparam logic [9:0]  DEF_RD_BURST      = 10'd256;
    localparam logic [10:0] DEF_RD_FIFO_DEPTH = 11'd1024;

endpackage

// File: rtl/sdram_addr_ptr.sv
// sdram_addr_ptr: frame-region address pointer with rewind, wrap and tail-trimmed burst length
module sdram_addr_ptr
    import sdram_arb_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] MIN_ADDR = DEF_MIN_ADDR,
    parameter logic [ADDR_W-1:0] MAX_ADDR = DEF_MAX_ADDR,
    parameter logic [9:0]        BURST    = DEF_WR_BURST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              start,
    input  logic              adv,
    input  logic [9:0]        step,
    output logic [ADDR_W-1:0] addr,
    output logic [9:0]        len
);

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] lat;
    logic [ADDR_W-1:0] remain;
    logic [ADDR_W:0]   nxt;
    logic              hold;
    logic              dirty;

    // lat is the start address of the in-flight burst; a rewind during the
    // burst sets dirty so completion does not overwrite the rewound pointer
    assign remain = MAX_ADDR - ptr;
    assign len    = (remain < ADDR_W'(BURST)) ? remain[9:0] : BURST;
    assign nxt    = {1'b0, lat} + (ADDR_W + 1)'(step);
    assign addr   = hold ? lat : ptr;

    // pointer, latched burst address and in-flight/rewound flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= MIN_ADDR;
            lat   <= MIN_ADDR;
            hold  <= 1'b0;
            dirty <= 1'b0;
        end else begin
            if (load)
                ptr <= MIN_ADDR;
            else if (adv && !dirty)
                ptr <= (nxt >= {1'b0, MAX_ADDR}) ? MIN_ADDR : nxt[ADDR_W-1:0];
            if (start)
                lat <= ptr;
            hold  <= start | (hold & ~adv);
            dirty <= load | (dirty & ~start);
        end
    end

endmodule

// File: rtl/sdram_req_arb.sv
// sdram_req_arb: fair write/read request arbiter driving the SDRAM controller req/ack interface
module sdram_req_arb
    import sdram_arb_pkg::*;
#(
    parameter int                ADDR_W        = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] MIN_ADDR      = DEF_MIN_ADDR,
    parameter logic [ADDR_W-1:0] MAX_ADDR      = DEF_MAX_ADDR,
    parameter logic [9:0]        WR_BURST      = DEF_WR_BURST,
    parameter logic [9:0]        RD_BURST      = DEF_RD_BURST,
    parameter logic [10:0]       RD_FIFO_DEPTH = DEF_RD_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic [9:0]        wr_fifo_cnt,
    input  logic [10:0]       rd_fifo_cnt,
    input  logic              rd_valid,
    input  logic              wr_load,
    input  logic              rd_load,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [9:0]        sdram_wr_burst,
    output logic [9:0]        sdram_rd_burst
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       last_wr;
    logic       last_wr_nxt;
    logic [9:0] wlen;
    logic [9:0] rlen;
    logic       wr_elig;
    logic       rd_elig;
    logic       wr_start;
    logic       rd_start;
    logic       wr_adv;
    logic       rd_adv;

    sdram_addr_ptr #(
        .ADDR_W  (ADDR_W),
        .MIN_ADDR(MIN_ADDR),
        .MAX_ADDR(MAX_ADDR),
        .BURST   (WR_BURST)
    ) u_wr_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (wr_load),
        .start(wr_start),
        .adv  (wr_adv),
        .step (sdram_wr_burst),
        .addr (sdram_wr_addr),
        .len  (wlen)
    );

    sdram_addr_ptr #(
        .ADDR_W  (ADDR_W),
        .MIN_ADDR(MIN_ADDR),
        .MAX_ADDR(MAX_ADDR),
        .BURST   (RD_BURST)
    ) u_rd_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (rd_load),
        .start(rd_start),
        .adv  (rd_adv),
        .step (sdram_rd_burst),
        .addr (sdram_rd_addr),
        .len  (rlen)
    );

    // a read is only issued when the whole burst is guaranteed to fit in the read FIFO
    assign wr_elig = sdram_init_done & (wr_fifo_cnt >= wlen);
    assign rd_elig = sdram_init_done & rd_valid &
                     (({1'b0, rd_fifo_cnt} + {2'b0, rlen}) <= {1'b0, RD_FIFO_DEPTH});

    assign sdram_wr_req = (state == WREQ);
    assign sdram_rd_req = (state == RREQ);

    // state, fairness history and the burst length presented with each request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_wr        <= 1'b0;
            sdram_wr_burst <= WR_BURST;
            sdram_rd_burst <= RD_BURST;
        end else begin
            state   <= state_nxt;
            last_wr <= last_wr_nxt;
            if (wr_start)
                sdram_wr_burst <= wlen;
            if (rd_start)
                sdram_rd_burst <= rlen;
        end
    end

    // grant the side not served last on a tie; complete once the matching ack falls
    always_comb begin
        state_nxt   = state;
        last_wr_nxt = last_wr;
        wr_start    = 1'b0;
        rd_start    = 1'b0;
        wr_adv      = 1'b0;
        rd_adv      = 1'b0;
        case (state)
            IDLE: begin
                if (wr_elig && (!rd_elig || !last_wr)) begin
                    wr_start  = 1'b1;
                    state_nxt = WREQ;
                end else if (rd_elig) begin
                    rd_start  = 1'b1;
                    state_nxt = RREQ;
                end
            end
            WREQ:  state_nxt = sdram_wr_ack ? WBUSY : WREQ;
            WBUSY: begin
                if (!sdram_wr_ack) begin
                    wr_adv      = 1'b1;
                    last_wr_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            RREQ:  state_nxt = sdram_rd_ack ? RBUSY : RREQ;
            RBUSY: begin
                if (!sdram_rd_ack) begin
                    rd_adv      = 1'b1;
                    last_wr_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sdram_req_arb.sv
// tb_sdram_req_arb: scoreboard bench for the SDRAM request arbiter on a 1000-word frame
module tb_sdram_req_arb;

    typedef struct {
        logic wr;
        int   addr;
        int   burst;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic        sdram_init_done;
    logic [9:0]  wr_fifo_cnt;
    logic [10:0] rd_fifo_cnt;
    logic        rd_valid;
    logic        wr_load;
    logic        rd_load;
    logic        sdram_wr_ack;
    logic        sdram_rd_ack;
    logic        sdram_wr_req;
    logic        sdram_rd_req;
    logic [23:0] sdram_wr_addr;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_wr_burst;
    logic [9:0]  sdram_rd_burst;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   seen = 0;
    logic auto_ack = 1'b0;
    int   base;

    sdram_req_arb #(
        .ADDR_W       (24),
        .MIN_ADDR     (24'd0),
        .MAX_ADDR     (24'd1000),
        .WR_BURST     (10'd256),
        .RD_BURST     (10'd256),
        .RD_FIFO_DEPTH(11'd1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sdram_init_done(sdram_init_done),
        .wr_fifo_cnt    (wr_fifo_cnt),
        .rd_fifo_cnt    (rd_fifo_cnt),
        .rd_valid       (rd_valid),
        .wr_load        (wr_load),
        .rd_load        (rd_load),
        .sdram_wr_ack   (sdram_wr_ack),
        .sdram_rd_ack   (sdram_rd_ack),
        .sdram_wr_req   (sdram_wr_req),
        .sdram_rd_req   (sdram_rd_req),
        .sdram_wr_addr  (sdram_wr_addr),
        .sdram_rd_addr  (sdram_rd_addr),
        .sdram_wr_burst (sdram_wr_burst),
        .sdram_rd_burst (sdram_rd_burst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic wr, input int addr, input int burst);
        txn_t t;
        t.wr    = wr;
        t.addr  = addr;
        t.burst = burst;
        exp_q.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_reqs(input int n);
        int t = 0;
        while (seen < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_reqs", seen, n);
    endtask

    task automatic wait_req(input logic wr);
        int t = 0;
        while (!(wr ? sdram_wr_req : sdram_rd_req) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(wr ? "wait_wr_req" : "wait_rd_req", int'(wr ? sdram_wr_req : sdram_rd_req), 1);
    endtask

    // scoreboard monitor: each new request is compared against the next expected transaction
    initial begin
        txn_t e;
        logic prev_wr = 1'b0;
        logic prev_rd = 1'b0;
        int   a_addr;
        int   a_burst;
        forever begin
            @(negedge clk);
            if (rst_n && sdram_wr_req && sdram_rd_req) begin
                errors++;
                $display("FAIL req_exclusive: both requests high, required at most one");
            end
            if (rst_n && ((sdram_wr_req && !prev_wr) || (sdram_rd_req && !prev_rd))) begin
                seen++;
                a_addr  = sdram_wr_req ? int'(sdram_wr_addr) : int'(sdram_rd_addr);
                a_burst = sdram_wr_req ? int'(sdram_wr_burst) : int'(sdram_rd_burst);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got wr=%0d addr=%0d burst=%0d, required no request",
                             sdram_wr_req, a_addr, a_burst);
                end else begin
                    e = exp_q.pop_front();
                    if (sdram_wr_req !== e.wr || a_addr != e.addr || a_burst != e.burst) begin
                        errors++;
                        $display("FAIL txn%0d: got wr=%0d addr=%0d burst=%0d, required wr=%0d addr=%0d burst=%0d",
                                 seen, sdram_wr_req, a_addr, a_burst, e.wr, e.addr, e.burst);
                    end
                end
            end
            prev_wr = sdram_wr_req;
            prev_rd = sdram_rd_req;
        end
    end

    // controller model: 1-cycle write ack, read ack held one cycle per burst word
    initial begin
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && rst_n && sdram_wr_req) begin
                @(posedge clk); #1 sdram_wr_ack = 1'b1;
                @(posedge clk); #1 sdram_wr_ack = 1'b0;
            end else if (auto_ack && rst_n && sdram_rd_req) begin
                @(posedge clk); #1 sdram_rd_ack = 1'b1;
                repeat (int'(sdram_rd_burst)) @(posedge clk);
                #1 sdram_rd_ack = 1'b0;
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        sdram_init_done = 1'b0;
        wr_fifo_cnt     = 10'd0;
        rd_fifo_cnt     = 11'd0;
        rd_valid        = 1'b0;
        wr_load         = 1'b0;
        rd_load         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_req", int'(sdram_wr_req), 0);
        chk("rst_rd_req", int'(sdram_rd_req), 0);
        chk("rst_wr_addr", int'(sdram_wr_addr), 0);
        chk("rst_rd_addr", int'(sdram_rd_addr), 0);
        chk("rst_wr_burst", int'(sdram_wr_burst), 256);
        chk("rst_rd_burst", int'(sdram_rd_burst), 256);

        // single write, hand-driven ack
        push(1'b1, 0, 256);
        sdram_init_done = 1'b1;
        wr_fifo_cnt     = 10'd256;
        rst_n           = 1'b1;
        wait_req(1'b1);
        @(posedge clk); #1 sdram_wr_ack = 1'b1; wr_fifo_cnt = 10'd0;
        @(posedge clk); #1 sdram_wr_ack = 1'b0;
        @(negedge clk);
        chk("wr_req_drop", int'(sdram_wr_req), 0);
        @(negedge clk);
        chk("wr_addr_adv", int'(sdram_wr_addr), 256);

        // both eligible: alternation starts with read since write was served last
        push(1'b0, 0, 256);
        push(1'b1, 256, 256);
        push(1'b0, 256, 256);
        push(1'b1, 512, 256);
        auto_ack    = 1'b1;
        base        = seen;
        wr_fifo_cnt = 10'd300;
        rd_fifo_cnt = 11'd0;
        rd_valid    = 1'b1;
        wait_reqs(base + 1);
        repeat (100) @(negedge clk);
        chk("rd_busy_req", int'(sdram_rd_req), 0);
        chk("rd_busy_addr", int'(sdram_rd_addr), 0);
        wait_reqs(base + 4);
        wr_fifo_cnt = 10'd0;
        rd_valid    = 1'b0;
        repeat (20) @(negedge clk);
        chk("alt_wr_addr", int'(sdram_wr_addr), 768);
        chk("alt_rd_addr", int'(sdram_rd_addr), 512);

        // rewind, then four writes with a trimmed tail burst and wrap
        wr_load = 1'b1;
        @(negedge clk);
        wr_load = 1'b0;
        chk("wr_load_idle", int'(sdram_wr_addr), 0);
        push(1'b1, 0, 256);
        push(1'b1, 256, 256);
        push(1'b1, 512, 256);
        push(1'b1, 768, 232);
        base        = seen;
        wr_fifo_cnt = 10'd300;
        wait_reqs(base + 4);
        wr_fifo_cnt = 10'd0;
        repeat (10) @(negedge clk);
        chk("wrap_wr_addr", int'(sdram_wr_addr), 0);
        chk("tail_wr_burst", int'(sdram_wr_burst), 232);
        push(1'b1, 0, 256);
        base        = seen;
        wr_fifo_cnt = 10'd256;
        wait_reqs(base + 1);
        wr_fifo_cnt = 10'd0;
        repeat (10) @(negedge clk);
        chk("post_wrap_addr", int'(sdram_wr_addr), 256);

        // read FIFO headroom boundary
        base        = seen;
        rd_fifo_cnt = 11'd800;
        rd_valid    = 1'b1;
        repeat (30) @(negedge clk);
        chk("rd_no_room", seen, base);
        push(1'b0, 512, 256);
        rd_fifo_cnt = 11'd768;
        wait_reqs(base + 1);
        rd_valid = 1'b0;
        repeat (300) @(negedge clk);
        chk("rd_room_addr", int'(sdram_rd_addr), 768);

        // rewind colliding with write completion
        push(1'b1, 256, 256);
        base        = seen;
        wr_fifo_cnt = 10'd256;
        wait_reqs(base + 1);
        wr_fifo_cnt = 10'd0;
        repeat (10) @(negedge clk);
        chk("pre_load_addr", int'(sdram_wr_addr), 512);
        auto_ack = 1'b0;
        push(1'b1, 512, 256);
        wr_fifo_cnt = 10'd256;
        wait_req(1'b1);
        @(posedge clk); #1 sdram_wr_ack = 1'b1; wr_fifo_cnt = 10'd0;
        @(posedge clk); #1 sdram_wr_ack = 1'b0; wr_load = 1'b1;
        @(posedge clk); #1 wr_load = 1'b0;
        @(negedge clk);
        chk("load_wins_addr", int'(sdram_wr_addr), 0);

        // controller not initialised: nothing issued despite full FIFOs
        auto_ack        = 1'b1;
        base            = seen;
        sdram_init_done = 1'b0;
        wr_fifo_cnt     = 10'd1023;
        rd_fifo_cnt     = 11'd0;
        rd_valid        = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_init_reqs", seen, base);

        // asynchronous reset while a read request is pending
        auto_ack        = 1'b0;
        wr_fifo_cnt     = 10'd0;
        sdram_init_done = 1'b1;
        push(1'b0, 768, 232);
        wait_req(1'b0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_rd_req", int'(sdram_rd_req), 0);
        chk("arst_rd_addr", int'(sdram_rd_addr), 0);
        chk("arst_wr_addr", int'(sdram_wr_addr), 0);
        chk("arst_rd_burst", int'(sdram_rd_burst), 256);
        rd_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // stray read ack while idle must not start or complete anything
        @(negedge clk);
        sdram_rd_ack = 1'b1;
        repeat (3) @(negedge clk);
        sdram_rd_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("stray_ack_req", int'(sdram_rd_req), 0);
        chk("stray_ack_addr", int'(sdram_rd_addr), 0);
        auto_ack = 1'b1;
        push(1'b1, 0, 256);
        base        = seen;
        wr_fifo_cnt = 10'd256;
        wait_reqs(base + 1);
        wr_fifo_cnt = 10'd0;
        repeat (10) @(negedge clk);
        chk("after_stray_wr_addr", int'(sdram_wr_addr), 256);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
